// File: rtl/vtc_pkg.sv
// vtc_pkg: shared state, geometry types and config validation for video_timing_ctrl
package vtc_pkg;
  localparam int VTC_H_W = 12;
  localparam int VTC_V_W = 11;
  typedef enum logic [1:0] {IDLE, RUN, STOP_PEND} vtc_state_e;
  typedef struct packed {
    logic [VTC_H_W-1:0] h_active;
    logic [VTC_H_W-1:0] h_fp;
    logic [VTC_H_W-1:0] h_sync;
    logic [VTC_H_W-1:0] h_bp;
    logic [VTC_V_W-1:0] v_active;
    logic [VTC_V_W-1:0] v_fp;
    logic [VTC_V_W-1:0] v_sync;
    logic [VTC_V_W-1:0] v_bp;
  } vtc_cfg_t;
  function automatic logic vtc_cfg_ok(input vtc_cfg_t cfg);
    logic [VTC_H_W+1:0] ht;
    logic [VTC_V_W+1:0] vt;
    ht = (VTC_H_W+2)'(cfg.h_active) + (VTC_H_W+2)'(cfg.h_fp) + (VTC_H_W+2)'(cfg.h_sync) + (VTC_H_W+2)'(cfg.h_bp);
    vt = (VTC_V_W+2)'(cfg.v_active) + (VTC_V_W+2)'(cfg.v_fp) + (VTC_V_W+2)'(cfg.v_sync) + (VTC_V_W+2)'(cfg.v_bp);
    return |cfg.h_active && |cfg.h_sync && |cfg.v_active && |cfg.v_sync &&
           ht >= (VTC_H_W+2)'(4) && vt >= (VTC_V_W+2)'(2) &&
           ht[VTC_H_W+1:VTC_H_W] == 2'b00 && vt[VTC_V_W+1:VTC_V_W] == 2'b00;
  endfunction
endpackage

// File: rtl/vtc_axis_cnt.sv
// vtc_axis_cnt: one raster axis counter with active/sync region decode and wrap flag
module vtc_axis_cnt #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic [W-1:0] active,
  input  logic [W-1:0] fp,
  input  logic [W-1:0] sync,
  input  logic [W-1:0] bp,
  output logic [W-1:0] cnt,
  output logic         in_active,
  output logic         in_sync,
  output logic         wrap
);
  logic [W:0] sync_lo, sync_hi, total;
  assign sync_lo   = {1'b0, active} + {1'b0, fp};
  assign sync_hi   = sync_lo + {1'b0, sync};
  assign total     = sync_hi + {1'b0, bp};
  assign in_active = cnt < active;
  assign in_sync   = {1'b0, cnt} >= sync_lo && {1'b0, cnt} < sync_hi;
  assign wrap      = {1'b0, cnt} == total - (W+1)'(1);
  // advance when enabled, returning to 0 after the last position of the axis
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt <= '0;
    else cnt <= !en ? cnt : wrap ? '0 : cnt + W'(1);
endmodule

// File: rtl/video_timing_ctrl.sv
// video_timing_ctrl: raster sequencer with frame-boundary config shadowing and start/stop control
module video_timing_ctrl
  import vtc_pkg::*;
#(
  parameter int   H_W      = VTC_H_W,
  parameter int   V_W      = VTC_V_W,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           i_enable,
  input  logic           i_single,
  input  logic           i_cfg_update,
  input  logic [H_W-1:0] i_h_active,
  input  logic [H_W-1:0] i_h_fp,
  input  logic [H_W-1:0] i_h_sync,
  input  logic [H_W-1:0] i_h_bp,
  input  logic [V_W-1:0] i_v_active,
  input  logic [V_W-1:0] i_v_fp,
  input  logic [V_W-1:0] i_v_sync,
  input  logic [V_W-1:0] i_v_bp,
  output logic           o_vs,
  output logic           o_hs,
  output logic           o_de,
  output logic [H_W-1:0] o_cnt_ch,
  output logic [V_W-1:0] o_cnt_line,
  output logic           o_frame_start,
  output logic           o_line_end,
  output logic           o_busy,
  output logic           o_cfg_err
);
  vtc_state_e     state, state_nx;
  vtc_cfg_t       shadow, pending, cfg_in;
  logic           pend_vld, single_q, run, frame_end, take, de_nx, cfg_in_ok;
  logic           h_act, h_syn, h_wrap, v_act, v_syn, v_wrap;
  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;
  assign cfg_in    = '{h_active: i_h_active, h_fp: i_h_fp, h_sync: i_h_sync, h_bp: i_h_bp,
                       v_active: i_v_active, v_fp: i_v_fp, v_sync: i_v_sync, v_bp: i_v_bp};
  assign cfg_in_ok = vtc_cfg_ok(cfg_in);
  assign run       = state != IDLE;
  assign frame_end = run && h_wrap && v_wrap;
  assign take      = pend_vld && (state == IDLE || frame_end);
  assign de_nx     = run && h_act && v_act;
  vtc_axis_cnt #(.W(H_W)) u_h (
    .clk(clk), .rstn(rstn), .en(run),
    .active(shadow.h_active), .fp(shadow.h_fp), .sync(shadow.h_sync), .bp(shadow.h_bp),
    .cnt(h_cnt), .in_active(h_act), .in_sync(h_syn), .wrap(h_wrap)
  );
  vtc_axis_cnt #(.W(V_W)) u_v (
    .clk(clk), .rstn(rstn), .en(run && h_wrap),
    .active(shadow.v_active), .fp(shadow.v_fp), .sync(shadow.v_sync), .bp(shadow.v_bp),
    .cnt(v_cnt), .in_active(v_act), .in_sync(v_syn), .wrap(v_wrap)
  );
  // start needs a valid shadow; a running frame always completes before stopping
  always_comb begin
    state_nx = state == IDLE ? ((i_enable || i_single) && vtc_cfg_ok(shadow) ? RUN : IDLE) :
               frame_end     ? (i_enable && !single_q ? RUN : IDLE) :
               (i_enable || single_q) ? RUN : STOP_PEND;
  end
  // state register; single-shot flag is armed at start and consumed at frame end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state    <= IDLE;
      single_q <= 1'b0;
    end else begin
      state    <= state_nx;
      single_q <= state == IDLE ? i_single && !i_enable : single_q && !frame_end;
    end
  // pending set is promoted to shadow at a boundary; a same-cycle update queues behind it
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      shadow   <= '0;
      pending  <= '0;
      pend_vld <= 1'b0;
    end else begin
      if (take) begin
        shadow   <= pending;
        pend_vld <= 1'b0;
      end
      if (i_cfg_update && cfg_in_ok) begin
        pending  <= cfg_in;
        pend_vld <= 1'b1;
      end
    end
  // registered raster outputs, one clock behind the counters
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      o_vs          <= ~SYNC_POL;
      o_hs          <= ~SYNC_POL;
      o_de          <= 1'b0;
      o_cnt_ch      <= '0;
      o_cnt_line    <= '0;
      o_frame_start <= 1'b0;
      o_line_end    <= 1'b0;
      o_busy        <= 1'b0;
      o_cfg_err     <= 1'b0;
    end else begin
      o_vs          <= run && v_syn ? SYNC_POL : ~SYNC_POL;
      o_hs          <= run && h_syn ? SYNC_POL : ~SYNC_POL;
      o_de          <= de_nx;
      o_cnt_ch      <= de_nx ? h_cnt : '0;
      o_cnt_line    <= de_nx ? v_cnt : '0;
      o_frame_start <= run && h_cnt == '0 && v_cnt == '0;
      o_line_end    <= de_nx && h_cnt == shadow.h_active - VTC_H_W'(1);
      o_busy        <= run;
      o_cfg_err     <= i_cfg_update && !cfg_in_ok;
    end
endmodule

// File: tb/tb_video_timing_ctrl.sv
// tb_video_timing_ctrl: directed raster, config-shadowing, start/stop and reset checks
module tb_video_timing_ctrl;
  logic        clk = 1'b0, rstn = 1'b0, i_enable = 1'b0, i_single = 1'b0, i_cfg_update = 1'b0;
  logic [11:0] i_h_active = '0, i_h_fp = '0, i_h_sync = '0, i_h_bp = '0;
  logic [10:0] i_v_active = '0, i_v_fp = '0, i_v_sync = '0, i_v_bp = '0;
  logic        o_vs, o_hs, o_de, o_frame_start, o_line_end, o_busy, o_cfg_err;
  logic [11:0] o_cnt_ch;
  logic [10:0] o_cnt_line;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  video_timing_ctrl dut (
    .clk(clk), .rstn(rstn), .i_enable(i_enable), .i_single(i_single), .i_cfg_update(i_cfg_update),
    .i_h_active(i_h_active), .i_h_fp(i_h_fp), .i_h_sync(i_h_sync), .i_h_bp(i_h_bp),
    .i_v_active(i_v_active), .i_v_fp(i_v_fp), .i_v_sync(i_v_sync), .i_v_bp(i_v_bp),
    .o_vs(o_vs), .o_hs(o_hs), .o_de(o_de), .o_cnt_ch(o_cnt_ch), .o_cnt_line(o_cnt_line),
    .o_frame_start(o_frame_start), .o_line_end(o_line_end), .o_busy(o_busy), .o_cfg_err(o_cfg_err)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int ha, hf, hs, hb, va, vf, vs, vb);
    i_h_active = 12'(ha); i_h_fp = 12'(hf); i_h_sync = 12'(hs); i_h_bp = 12'(hb);
    i_v_active = 11'(va); i_v_fp = 11'(vf); i_v_sync = 11'(vs); i_v_bp = 11'(vb);
  endtask

  function automatic logic [31:0] all_outs();
    return {2'b00, o_vs, o_hs, o_de, o_line_end, o_frame_start, o_busy, o_cfg_err, o_cnt_ch, o_cnt_line};
  endfunction

  // Checks one whole frame, one comparison per pixel clock, starting on the clock after the
  // counters sit at (0,0). Optional mid-frame actions are applied after the sample at cycle c.
  task automatic check_frame(input string tag, input int ha, hf, hs, hb, va, vf, vs, vb,
                             input int upd_at, input bit bad, input int drop_at, input int raise_at);
    int ht, vt, c;
    logic de;
    logic [31:0] exp_v, obs_v;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    for (int v = 0; v < vt; v++)
      for (int h = 0; h < ht; h++) begin
        c = v * ht + h;
        tick;
        de = h < ha && v < va;
        exp_v = {2'b00, v >= va + vf && v < va + vf + vs, h >= ha + hf && h < ha + hf + hs, de,
                 de && h == ha - 1, c == 0, 1'b1, bad && c == upd_at + 1,
                 de ? 12'(h) : 12'd0, de ? 11'(v) : 11'd0};
        obs_v = {2'b00, o_vs, o_hs, o_de, o_line_end, o_frame_start, o_busy, o_cfg_err,
                 de ? o_cnt_ch : 12'd0, de ? o_cnt_line : 11'd0};
        chk($sformatf("%s c%0d", tag, c), obs_v, exp_v);
        if (c == upd_at) i_cfg_update = 1'b1;
        if (c == upd_at + 1) i_cfg_update = 1'b0;
        if (c == drop_at) i_enable = 1'b0;
        if (c == raise_at) i_enable = 1'b1;
      end
  endtask

  initial begin
    set_cfg(4, 1, 2, 1, 3, 1, 1, 1);
    repeat (3) tick;
    chk("reset_outputs", all_outs(), 32'd0);
    rstn = 1'b1;
    tick;
    i_single = 1'b1; tick; i_single = 1'b0;
    repeat (3) tick;
    chk("single_without_shadow", all_outs(), 32'd0);
    i_cfg_update = 1'b1; tick; i_cfg_update = 1'b0;
    tick;
    chk("cfg_loaded_idle", all_outs(), 32'd0);
    i_single = 1'b1; tick; i_single = 1'b0;
    chk("pre_first_frame", all_outs(), 32'd0);
    check_frame("f1_single", 4, 1, 2, 1, 3, 1, 1, 1, -1, 1'b0, -1, -1);
    tick;
    chk("f1_back_idle", all_outs(), 32'd0);
    repeat (4) tick;
    chk("f1_stays_idle", {31'd0, o_busy}, 32'd0);
    i_enable = 1'b1; tick;
    check_frame("f2_cont", 4, 1, 2, 1, 3, 1, 1, 1, -1, 1'b0, -1, -1);
    set_cfg(6, 1, 1, 1, 3, 1, 1, 1);
    check_frame("f3_cfg_b_mid", 4, 1, 2, 1, 3, 1, 1, 1, 10, 1'b0, -1, -1);
    i_h_sync = 12'd0;
    check_frame("f4_b_bad_cfg", 6, 1, 1, 1, 3, 1, 1, 1, 5, 1'b1, -1, -1);
    set_cfg(4, 1, 2, 1, 3, 1, 1, 1);
    check_frame("f5_b_kept", 6, 1, 1, 1, 3, 1, 1, 1, 10, 1'b0, -1, -1);
    check_frame("f6_a_drop", 4, 1, 2, 1, 3, 1, 1, 1, -1, 1'b0, 10, -1);
    tick;
    chk("f6_back_idle", all_outs(), 32'd0);
    tick;
    chk("f6_stays_idle", {31'd0, o_busy}, 32'd0);
    i_enable = 1'b1; tick;
    check_frame("f7_drop_raise", 4, 1, 2, 1, 3, 1, 1, 1, -1, 1'b0, 10, 20);
    check_frame("f8_after_raise", 4, 1, 2, 1, 3, 1, 1, 1, -1, 1'b0, -1, -1);
    repeat (30) tick;
    chk("pre_reset_busy_hs", {30'd0, o_busy, o_hs}, 32'd3);
    rstn = 1'b0; i_enable = 1'b0;
    #1;
    chk("async_reset", all_outs(), 32'd0);
    repeat (2) tick;
    rstn = 1'b1;
    i_cfg_update = 1'b1; tick; i_cfg_update = 1'b0;
    tick;
    i_single = 1'b1; tick; i_single = 1'b0;
    check_frame("f10_post_reset", 4, 1, 2, 1, 3, 1, 1, 1, -1, 1'b0, -1, -1);
    tick;
    chk("f10_back_idle", all_outs(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
